// File: rtl/mips_run_ctrl.sv
// -----------------------------------------------------------------------------
// mips_run_ctrl
//   Run controller for the mips core. It sequences the core reset, counts run
//   cycles and ends a run on a cycle budget, a halt address, a syscall
//   instruction or a PC self-loop. It sits beside the core and watches the
//   core's pc/instr debug outputs. done_o/done_code_o can feed $finish in
//   simulation or status LEDs on a board.
//
// Parameters
//   PC_WIDTH      width of pc_i and HALT_ADDR
//   CNT_WIDTH     width of the run-cycle counter
//   RESET_CYCLES  clocks the core reset is held after start (>=1)
//   MAX_CYCLES    run-cycle budget before timeout (>=1, truncated to CNT_WIDTH)
//   HALT_ADDR     pc value that ends the run
//   STALL_LIMIT   consecutive cycles with an unchanged pc that count as a
//                 self-loop (>=2)
//   SYSCALL_HALT  1: instr 32'h0000_000C ends the run, 0: syscall ignored
//
// Ports
//   clock_i        rising-edge clock
//   reset_i        asynchronous active-high reset, returns the block to IDLE
//   start_i        starts a run from IDLE or DONE (ignored in HOLD/RUN)
//   pc_i           core program counter (debug)
//   instr_i        instruction currently fetched (debug)
//   cpu_reset_o    reset to the mips core
//   running_o      high in RUN
//   done_o         high in DONE
//   done_code_o    0 none, 1 timeout, 2 halt (addr or syscall), 3 self-loop
//   cycle_count_o  RUN cycles elapsed in the current/last run
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module mips_run_ctrl #(
  parameter int                  PC_WIDTH     = 32,
  parameter int                  CNT_WIDTH    = 32,
  parameter int                  RESET_CYCLES = 2,
  parameter int                  MAX_CYCLES   = 100,
  parameter logic [PC_WIDTH-1:0] HALT_ADDR    = PC_WIDTH'(32'hFFFF_FFFC),
  parameter int                  STALL_LIMIT  = 8,
  parameter bit                  SYSCALL_HALT = 1'b1
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [PC_WIDTH-1:0]  pc_i,
  input  logic [31:0]          instr_i,
  output logic                 cpu_reset_o,
  output logic                 running_o,
  output logic                 done_o,
  output logic [1:0]           done_code_o,
  output logic [CNT_WIDTH-1:0] cycle_count_o
);

  // Hold counter must be able to represent RESET_CYCLES itself.
  localparam int HOLD_W  = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);
  // Stall counter must be able to represent STALL_LIMIT itself.
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  localparam logic [HOLD_W-1:0]    HOLD_END  = HOLD_W'(RESET_CYCLES);
  localparam logic [STALL_W-1:0]   STALL_LIM = STALL_W'(STALL_LIMIT);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT   = CNT_WIDTH'(MAX_CYCLES);
  localparam logic [31:0]          SYSCALL   = 32'h0000_000C;

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_TIMEOUT = 2'd1;
  localparam logic [1:0] CODE_HALT    = 2'd2;
  localparam logic [1:0] CODE_LOOP    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q;
  logic                 cpu_reset_q;
  logic                 running_q;
  logic                 done_q;
  logic [1:0]           code_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [HOLD_W-1:0]    hold_q;
  logic [STALL_W-1:0]   stall_q;
  logic [PC_WIDTH-1:0]  last_pc_q;

  // Next-state values for the RUN datapath.
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [STALL_W-1:0]   stall_d;
  logic                 first_run;
  logic                 pc_same;
  logic                 halt_hit;
  logic                 loop_hit;
  logic                 tmo_hit;
  logic                 end_hit;
  logic [1:0]           end_code_d;

  always_comb begin
    // Counter saturates at all-ones instead of wrapping.
    cnt_d = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    // The counter is only zero on the first RUN cycle; that cycle just
    // loads last_pc and starts the stall count at 1.
    first_run = (cnt_q == '0);
    pc_same   = !first_run && (pc_i == last_pc_q);

    stall_d = '0;
    if (pc_same) begin
      stall_d = (stall_q == STALL_LIM) ? stall_q : stall_q + 1'b1;
    end else begin
      stall_d = STALL_W'(1);
    end

    halt_hit = (pc_i == HALT_ADDR) || (SYSCALL_HALT && (instr_i == SYSCALL));
    loop_hit = (stall_d >= STALL_LIM);
    tmo_hit  = (cnt_d == MAX_CNT);
    end_hit  = halt_hit || loop_hit || tmo_hit;

    // Priority: halt, then self-loop, then timeout.
    end_code_d = CODE_NONE;
    if (halt_hit) begin
      end_code_d = CODE_HALT;
    end else if (loop_hit) begin
      end_code_d = CODE_LOOP;
    end else if (tmo_hit) begin
      end_code_d = CODE_TIMEOUT;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      code_q      <= CODE_NONE;
      cnt_q       <= '0;
      hold_q      <= '0;
      stall_q     <= '0;
      last_pc_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cpu_reset_q <= 1'b1;
          if (start_i) begin
            state_q   <= S_HOLD;
            hold_q    <= '0;
            cnt_q     <= '0;
            code_q    <= CODE_NONE;
            stall_q   <= '0;
            last_pc_q <= '0;
          end
        end

        S_HOLD: begin
          // Core reset drops on the same edge that raises running.
          if (hold_q == HOLD_END) begin
            state_q     <= S_RUN;
            cpu_reset_q <= 1'b0;
            running_q   <= 1'b1;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end

        S_RUN: begin
          cnt_q     <= cnt_d;
          stall_q   <= stall_d;
          last_pc_q <= pc_i;
          if (end_hit) begin
            state_q     <= S_DONE;
            running_q   <= 1'b0;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b1;
            code_q      <= end_code_d;
          end
        end

        S_DONE: begin
          // Core stays frozen; count and code are held until a new start.
          if (start_i) begin
            state_q   <= S_HOLD;
            done_q    <= 1'b0;
            hold_q    <= '0;
            cnt_q     <= '0;
            code_q    <= CODE_NONE;
            stall_q   <= '0;
            last_pc_q <= '0;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          cpu_reset_q <= 1'b1;
          running_q   <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_reset_o   = cpu_reset_q;
  assign running_o     = running_q;
  assign done_o        = done_q;
  assign done_code_o   = code_q;
  assign cycle_count_o = cnt_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl. Two instances share all inputs; they differ only in
// SYSCALL_HALT. Each run pushes the expected end code/count for both instances
// into their scoreboards; per-instance monitors pop and compare on done rise.
module tb_mips_run_ctrl;

  localparam logic [31:0] HALT = 32'hFFFF_FFFC;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] pc;
  logic [31:0] instr;

  logic        cpu_reset1, running1, done1;
  logic [1:0]  code1;
  logic [31:0] count1;
  logic        cpu_reset0, running0, done0;
  logic [1:0]  code0;
  logic [31:0] count0;

  typedef struct {
    logic [1:0]  code;
    logic [31:0] cnt;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  int n_tests = 0;
  int n_fail  = 0;

  mips_run_ctrl #(
    .PC_WIDTH(32), .CNT_WIDTH(32), .RESET_CYCLES(2), .MAX_CYCLES(100),
    .HALT_ADDR(HALT), .STALL_LIMIT(8), .SYSCALL_HALT(1'b1)
  ) u_dut1 (
    .clock_i(clk), .reset_i(rst), .start_i(start), .pc_i(pc), .instr_i(instr),
    .cpu_reset_o(cpu_reset1), .running_o(running1), .done_o(done1),
    .done_code_o(code1), .cycle_count_o(count1)
  );

  mips_run_ctrl #(
    .PC_WIDTH(32), .CNT_WIDTH(32), .RESET_CYCLES(2), .MAX_CYCLES(100),
    .HALT_ADDR(HALT), .STALL_LIMIT(8), .SYSCALL_HALT(1'b0)
  ) u_dut0 (
    .clock_i(clk), .reset_i(rst), .start_i(start), .pc_i(pc), .instr_i(instr),
    .cpu_reset_o(cpu_reset0), .running_o(running0), .done_o(done0),
    .done_code_o(code0), .cycle_count_o(count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: compare whenever an instance raises done.
  logic dprev1 = 1'b0;
  logic dprev0 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (done1 && !dprev1) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut1_unexpected_done: got code %0d, expected no done", code1);
      end else begin
        e = q1.pop_front();
        check("dut1_code", 64'(code1), 64'(e.code));
        check("dut1_count", 64'(count1), 64'(e.cnt));
        check("dut1_cpu_reset_at_done", 64'(cpu_reset1), 64'd1);
        check("dut1_running_at_done", 64'(running1), 64'd0);
      end
    end
    dprev1 <= done1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done0 && !dprev0) begin
      if (q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut0_unexpected_done: got code %0d, expected no done", code0);
      end else begin
        e = q0.pop_front();
        check("dut0_code", 64'(code0), 64'(e.code));
        check("dut0_count", 64'(count0), 64'(e.cnt));
        check("dut0_cpu_reset_at_done", 64'(cpu_reset0), 64'd1);
      end
    end
    dprev0 <= done0;
  end

  // pc/instr seen at run cycle k (the edge that makes cycle_count == k).
  function automatic logic [31:0] pc_for(input int mode, input int k);
    logic [31:0] v;
    v = 32'(4 * k);
    case (mode)
      1:       if (k == 37) v = HALT;
      3, 4:    if (k >= 20) v = 32'h0000_0040;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] instr_for(input int mode, input int k);
    if (mode == 2 && k == 10) return 32'h0000_000C;
    if (mode == 4 && k == 27) return 32'h0000_000C;
    return 32'h0;
  endfunction

  // One run. abort_at != 0 pulses reset at that run cycle instead of finishing.
  task automatic do_run(input int mode, input int abort_at,
                        input logic [1:0] c1, input logic [31:0] n1,
                        input logic [1:0] c0, input logic [31:0] n0);
    exp_t e;
    int k;
    if (abort_at == 0) begin
      e.code = c1; e.cnt = n1; q1.push_back(e);
      e.code = c0; e.cnt = n0; q0.push_back(e);
    end
    @(negedge clk); start = 1'b1; pc = '0; instr = '0;
    @(negedge clk); start = 1'b0;          // edge N consumed start
    @(negedge clk);                        // N+1
    @(negedge clk);                        // N+2
    check("hold_cpu_reset", 64'(cpu_reset1), 64'd1);
    check("hold_running", 64'(running1), 64'd0);
    @(negedge clk);                        // N+3: core reset released
    check("run_cpu_reset1", 64'(cpu_reset1), 64'd0);
    check("run_cpu_reset0", 64'(cpu_reset0), 64'd0);
    check("run_running", 64'(running1), 64'd1);
    check("run_count_start", 64'(count1), 64'd0);
    k = 1;
    forever begin
      pc    = pc_for(mode, k);
      instr = instr_for(mode, k);
      start = (k == 5);                    // must be ignored mid-run
      @(negedge clk);
      start = 1'b0;
      if (abort_at != 0 && k == abort_at) begin
        check("pre_abort_count", 64'(count1), 64'(abort_at));
        rst = 1'b1;
        #1;
        check("abort_cpu_reset", 64'(cpu_reset1), 64'd1);
        check("abort_count", 64'(count1), 64'd0);
        check("abort_running", 64'(running1), 64'd0);
        check("abort_done_code", 64'(code1), 64'd0);
        @(negedge clk); rst = 1'b0;
        return;
      end
      if (done1 && done0) break;
      k++;
      if (k > 150) begin
        n_tests++;
        n_fail++;
        $display("FAIL run_bound: mode %0d no done after 150 cycles, expected done", mode);
        return;
      end
    end
    // DONE must hold its results while pc wanders.
    pc = HALT; instr = 32'h0000_000C;
    repeat (3) @(negedge clk);
    check("hold_done", 64'(done1), 64'd1);
    check("hold_code", 64'(code1), 64'(c1));
    check("hold_count", 64'(count1), 64'(n1));
    check("hold_core_frozen", 64'(cpu_reset1), 64'd1);
    pc = '0; instr = '0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pc = '0; instr = '0;
    repeat (2) @(negedge clk);
    check("rst_cpu_reset", 64'(cpu_reset1), 64'd1);
    check("rst_running", 64'(running1), 64'd0);
    check("rst_done", 64'(done1), 64'd0);
    check("rst_code", 64'(code1), 64'd0);
    check("rst_count", 64'(count1), 64'd0);
    rst = 1'b0;

    do_run(0, 0,  2'd1, 32'd100, 2'd1, 32'd100);  // budget timeout, start ignored
    do_run(1, 0,  2'd2, 32'd37,  2'd2, 32'd37);   // halt address
    do_run(2, 0,  2'd2, 32'd10,  2'd1, 32'd100);  // syscall vs. syscall ignored
    do_run(3, 0,  2'd3, 32'd27,  2'd3, 32'd27);   // self-loop
    do_run(4, 0,  2'd2, 32'd27,  2'd3, 32'd27);   // halt beats self-loop
    do_run(0, 50, 2'd0, 32'd0,   2'd0, 32'd0);    // reset mid-run
    do_run(1, 0,  2'd2, 32'd37,  2'd2, 32'd37);   // clean run after reset

    check("sb1_empty", 64'(q1.size()), 64'd0);
    check("sb0_empty", 64'(q0.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
